sw_w_mode_ctrl: RTL
===================

Name: sw_w_mode_ctrl

Overview:
- Mode and control sequencer for the stopwatch/watch display path.
- Converts four debounced button levels into rising-edge events.
- Drives the 1-bit display select that chooses stopwatch time (0) or watch time (1).
- Drives the stopwatch run/clear controls and the watch time-set controls (field pointer, increment pulse), with an inactivity timeout that leaves set mode.

Parameters:
- SET_TIMEOUT_MS, 10000: number of i_tick pulses with no accepted button event before set mode auto-exits.
- TO_W, $clog2(SET_TIMEOUT_MS+1): timeout counter width (derived; do not override).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- i_btn_mode  input  1  debounced level; toggles display mode
- i_btn_run  input  1  debounced level; stopwatch run/stop, or watch field increment in set mode
- i_btn_clear  input  1  debounced level; stopwatch clear, or exit set mode
- i_btn_set  input  1  debounced level; enter set mode / advance field (watch mode only)
- i_tick  input  1  one-cycle 1 ms tick
- o_sel  output  1  display select: 0 = stopwatch, 1 = watch
- o_sw_run  output  1  level; stopwatch counting enable
- o_sw_clear  output  1  one-cycle pulse; clears stopwatch counters
- o_w_set  output  1  level; watch in set mode
- o_w_field  output  2  field being set: 0 = sec, 1 = min, 2 = hour (3 never driven)
- o_w_inc  output  1  one-cycle pulse; increment the selected watch field

Behaviour:
- Reset (reset = 0, asynchronous):
  - all outputs 0
  - state SW_STOP / W_RUN, o_sel = 0
  - timeout counter 0
  - edge-detector history registers reset to 1, so a button held through reset release produces no event.
- Edge events: ev_x = i_btn_x & ~prev_x, with prev_x registered every cycle.
- All outputs are registered. The response appears at the clk edge where the input is first sampled high (1-cycle latency from the input level change).
- Priority when several events occur in the same cycle: mode > clear > set > run. Lower-priority events in that cycle are discarded, not queued.
- Stopwatch sub-FSM (SW_STOP, SW_RUN):
  - Runs independently of o_sel; the stopwatch keeps counting while watch time is displayed.
  - Events act only when o_sel = 0.
  - SW_STOP + ev_run -> SW_RUN, o_sw_run = 1.
  - SW_RUN + ev_run -> SW_STOP, o_sw_run = 0.
  - SW_STOP + ev_clear -> o_sw_clear = 1 for exactly one cycle; state unchanged.
  - SW_RUN + ev_clear is ignored (no pulse).
  - ev_set is ignored.
- Watch sub-FSM (W_RUN, W_SET); events act only when o_sel = 1:
  - W_RUN + ev_set -> W_SET, o_w_set = 1, o_w_field = 0, timeout counter cleared.
  - W_SET + ev_set -> field 0 -> 1 -> 2; from 2 -> W_RUN, o_w_set = 0, o_w_field = 0.
  - W_SET + ev_run -> o_w_inc = 1 for one cycle; field unchanged. Value wrap is owned by the watch counter, not this block.
  - W_SET + ev_clear -> W_RUN, o_w_set = 0, o_w_field = 0.
  - W_RUN + ev_run / ev_clear is ignored.
- Mode event (any state): o_sel toggles.
  - If the watch is in W_SET, it is forced to W_RUN (o_w_set = 0, o_w_field = 0, counter cleared).
  - Stopwatch state is preserved.
- Timeout:
  - Active only in W_SET.
  - The counter increments on i_tick and clears on any accepted event.
  - When the counter reaches SET_TIMEOUT_MS-1 and i_tick = 1 -> W_RUN, same exit values as ev_clear.
  - An accepted event and a timeout in the same cycle: the event wins and the counter clears.
- o_w_inc and o_sw_clear are never high for more than one consecutive cycle.
- Asserting reset mid-operation immediately returns to the reset values, including a run in progress and a partially finished set.

Decomposition:
- Shared package sw_w_pkg:
  - field codes FLD_SEC = 2'd0, FLD_MIN = 2'd1, FLD_HOUR = 2'd2
  - state encodings SW_STOP/SW_RUN and W_RUN/W_SET
  - display select codes SEL_SW = 1'b0, SEL_W = 1'b1
- One sub-module btn_edge_det: per-button rising-edge detector, history reset to 1, instantiated four times.
- The FSMs and the timeout counter stay in the top level.

Test Plan:
1. Release reset with i_btn_run held high, then drop it -> no event; o_sw_run = 0 and o_sel = 0 throughout.
2. In stopwatch mode, run edge, wait 5 cycles, clear edge, run edge, clear edge:
   - o_sw_run = 1 one cycle after the first edge;
   - the first clear is ignored;
   - o_sw_run = 0 after the second run edge;
   - o_sw_clear pulses high for exactly 1 cycle after the final clear.
3. Stopwatch running, then mode edge:
   - o_sel = 1 and o_sw_run stays 1;
   - then set, run, run, set, set, set -> o_w_field steps 0 -> 1 -> 2, o_w_inc pulses twice while field = 0, o_w_set falls after the 4th set edge.
4. SET_TIMEOUT_MS = 5, enter W_SET, apply 4 ticks, run edge, then 5 ticks:
   - stays in set after the first 4 ticks;
   - the run edge clears the counter;
   - o_w_set falls on the 5th tick after the run edge.
5. In W_SET field 1, mode and run edges in the same cycle -> o_sel = 0, o_w_set = 0, o_w_field = 0, no o_w_inc pulse.
6. Assert reset mid-set while the stopwatch runs -> all outputs 0 immediately (asynchronous), before the next clk edge.

Source files
------------

// File: rtl/sw_w_pkg.sv
// -----------------------------------------------------------------------------
// sw_w_pkg
// Shared definitions for the stopwatch/watch mode sequencer:
//   - watch field codes (sec / min / hour)
//   - stopwatch and watch sub-FSM state encodings
//   - display select codes
// -----------------------------------------------------------------------------
package sw_w_pkg;

  // Watch field being edited in set mode. Code 3 is never produced.
  localparam logic [1:0] FLD_SEC  = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_HOUR = 2'd2;

  // Display select: which time the display path shows.
  localparam logic SEL_SW = 1'b0;
  localparam logic SEL_W  = 1'b1;

  // Stopwatch sub-FSM. SW_RUN is encoded as 1 so the run output is the state bit.
  typedef enum logic {
    SW_STOP = 1'b0,
    SW_RUN  = 1'b1
  } sw_state_t;

  // Watch sub-FSM.
  typedef enum logic {
    W_RUN = 1'b0,
    W_SET = 1'b1
  } w_state_t;

endpackage : sw_w_pkg

// File: rtl/btn_edge_det.sv
// -----------------------------------------------------------------------------
// btn_edge_det
// Rising-edge detector for one debounced button level.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   i_btn  - debounced button level
//   o_evt  - high in the cycle the level is first sampled high after being low
// -----------------------------------------------------------------------------
module btn_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_evt
);

  logic r_prev;

  // The history resets to 1 so a button already held when reset releases
  // looks like "still pressed" and produces no event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      r_prev <= i_btn;
    end
  end

  assign o_evt = i_btn & ~r_prev;

endmodule : btn_edge_det

// File: rtl/sw_w_mode_ctrl.sv
// -----------------------------------------------------------------------------
// sw_w_mode_ctrl
// Mode and control sequencer for the stopwatch/watch display path.
// Turns four button levels into edge events and drives the display select,
// stopwatch run/clear controls and watch time-set controls, with an
// inactivity timeout that leaves set mode.
// Parameters:
//   SET_TIMEOUT_MS - i_tick pulses without an accepted event before set exits
//   TO_W           - timeout counter width (derived, leave at default)
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   i_btn_mode     - toggles display select
//   i_btn_run      - stopwatch run/stop, or field increment in set mode
//   i_btn_clear    - stopwatch clear, or exit set mode
//   i_btn_set      - enter set mode / advance field (watch displayed only)
//   i_tick         - one-cycle 1 ms tick
//   o_sel          - display select: 0 stopwatch, 1 watch
//   o_sw_run       - stopwatch counting enable (level)
//   o_sw_clear     - one-cycle stopwatch clear pulse
//   o_w_set        - watch in set mode (level)
//   o_w_field      - field being set: 0 sec, 1 min, 2 hour
//   o_w_inc        - one-cycle increment pulse for the selected field
// -----------------------------------------------------------------------------
module sw_w_mode_ctrl
  import sw_w_pkg::*;
#(
  parameter int SET_TIMEOUT_MS = 10000,
  parameter int TO_W           = $clog2(SET_TIMEOUT_MS + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_set,
  input  logic       i_tick,
  output logic       o_sel,
  output logic       o_sw_run,
  output logic       o_sw_clear,
  output logic       o_w_set,
  output logic [1:0] o_w_field,
  output logic       o_w_inc
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SET_TIMEOUT_MS - 1);

  logic w_ev_mode;
  logic w_ev_run;
  logic w_ev_clear;
  logic w_ev_set;

  btn_edge_det u_edge_mode  (.clk(clk), .reset(reset), .i_btn(i_btn_mode),  .o_evt(w_ev_mode));
  btn_edge_det u_edge_run   (.clk(clk), .reset(reset), .i_btn(i_btn_run),   .o_evt(w_ev_run));
  btn_edge_det u_edge_clear (.clk(clk), .reset(reset), .i_btn(i_btn_clear), .o_evt(w_ev_clear));
  btn_edge_det u_edge_set   (.clk(clk), .reset(reset), .i_btn(i_btn_set),   .o_evt(w_ev_set));

  logic            r_sel;
  sw_state_t       r_sw_state;
  logic            r_sw_clear;
  w_state_t        r_w_state;
  logic [1:0]      r_w_field;
  logic            r_w_inc;
  logic [TO_W-1:0] r_to_cnt;

  // One event per cycle is served, highest priority first
  // (mode > clear > set > run); the rest are dropped. The timeout only
  // advances in a cycle with no event, so an event always wins over it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel      <= SEL_SW;
      r_sw_state <= SW_STOP;
      r_sw_clear <= 1'b0;
      r_w_state  <= W_RUN;
      r_w_field  <= FLD_SEC;
      r_w_inc    <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      // Pulses default low; edge events cannot repeat on consecutive cycles.
      r_sw_clear <= 1'b0;
      r_w_inc    <= 1'b0;

      if (w_ev_mode) begin
        // Switching display always abandons an unfinished set; the
        // stopwatch keeps whatever state it had.
        r_sel     <= ~r_sel;
        r_w_state <= W_RUN;
        r_w_field <= FLD_SEC;
        r_to_cnt  <= '0;
      end else if (w_ev_clear) begin
        if (r_sel == SEL_SW) begin
          if (r_sw_state == SW_STOP) r_sw_clear <= 1'b1;
        end else if (r_w_state == W_SET) begin
          r_w_state <= W_RUN;
          r_w_field <= FLD_SEC;
          r_to_cnt  <= '0;
        end
      end else if (w_ev_set) begin
        if (r_sel == SEL_W) begin
          r_to_cnt <= '0;
          if (r_w_state == W_RUN) begin
            r_w_state <= W_SET;
            r_w_field <= FLD_SEC;
          end else if (r_w_field == FLD_HOUR) begin
            r_w_state <= W_RUN;
            r_w_field <= FLD_SEC;
          end else begin
            r_w_field <= r_w_field + 2'd1;
          end
        end
      end else if (w_ev_run) begin
        if (r_sel == SEL_SW) begin
          r_sw_state <= (r_sw_state == SW_RUN) ? SW_STOP : SW_RUN;
        end else if (r_w_state == W_SET) begin
          r_w_inc  <= 1'b1;
          r_to_cnt <= '0;
        end
      end else if (r_w_state == W_SET && i_tick) begin
        if (r_to_cnt == TO_LAST) begin
          r_w_state <= W_RUN;
          r_w_field <= FLD_SEC;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
    end
  end

  assign o_sel      = r_sel;
  assign o_sw_run   = (r_sw_state == SW_RUN);
  assign o_sw_clear = r_sw_clear;
  assign o_w_set    = (r_w_state == W_SET);
  assign o_w_field  = r_w_field;
  assign o_w_inc    = r_w_inc;

endmodule : sw_w_mode_ctrl
